// File: rtl/spi_frame_tx_if.sv
// spi_frame_tx_if: SPI-side signals of the dummy camera frame transmitter.
//   CS_N       chip select, active-low (driven by master)
//   MOSI       command bit (driven by master)
//   MISO       frame data bit (driven by responder)
//   BUSY       high while a frame is being streamed
//   FRAME_DONE one-SCLK pulse at the end of a complete frame
//   FRAME_CNT  completed-frame counter
// Modports: master (system side / bench), slave (spi_frame_tx).
interface spi_frame_tx_if;
  logic       CS_N;
  logic       MOSI;
  logic       MISO;
  logic       BUSY;
  logic       FRAME_DONE;
  logic [7:0] FRAME_CNT;

  modport master (output CS_N, MOSI, input MISO, BUSY, FRAME_DONE, FRAME_CNT);
  modport slave  (input CS_N, MOSI, output MISO, BUSY, FRAME_DONE, FRAME_CNT);
endinterface

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI responder for the dummy 64x64 camera. Decodes an 8-bit
// command on MOSI; on CMD_READ streams one synthetic frame on MISO, MSB first,
// raster order, pixel = (x + y + FRAME_CNT) mod 2^PIX_BITS.
// Ports:
//   SCLK  SPI clock, all logic on posedge
//   RST   asynchronous, active-high reset (clears everything incl. FRAME_CNT)
//   bus   spi_frame_tx_if.slave: CS_N (high = async clear of the transaction,
//         FRAME_CNT kept), MOSI, MISO (registered), BUSY, FRAME_DONE, FRAME_CNT
// Optional: define SPI_TX_HEADER_EN to prefix each frame with a 16-bit header
// {8'h5A, FRAME_CNT}; when undefined no header logic exists.
module spi_frame_tx #(
  parameter int         WIDTH    = 64,
  parameter int         HEIGHT   = 64,
  parameter int         PIX_BITS = 8,
  parameter logic [7:0] CMD_READ = 8'hA5
) (
  input logic           SCLK,
  input logic           RST,
  spi_frame_tx_if.slave bus
);
  localparam int         XW      = $clog2(WIDTH);
  localparam int         YW      = $clog2(HEIGHT);
  localparam logic [2:0] PIX_MSB = 3'(PIX_BITS - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t          state;
  logic [6:0]      cmd;        // previous 7 command bits; the 8th comes straight off MOSI
  logic [2:0]      bitcnt;     // command bit count in CMD, current pixel bit index in DATA
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [7:0]      base;       // FRAME_CNT captured at frame start
  logic            miso, busy, frame_done;
  logic [7:0]      frame_cnt;

`ifdef SPI_TX_HEADER_EN
  localparam logic [7:0] HDR_TAG = 8'h5A;
  logic            in_hdr;
  logic [15:0]     hdr_sr;     // remaining header bits, next one at [15]
  logic [3:0]      hdr_left;   // header bits still to send after the current one
`endif

  logic            cs_n;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic            last_pix, pix_phase, cmd_hit, frame_end;
  logic [7:0]      cur_pix, nxt_pix;
  logic [2:0]      bm1;

  assign cs_n = bus.CS_N;

  // x wraps into y through plain overflow of the concatenated counter
  assign {ny, nx}  = {y, x} + (XW + YW)'(1);
  assign last_pix  = &{y, x};
  assign cur_pix   = 8'(x) + 8'(y) + base;
  assign nxt_pix   = 8'(nx) + 8'(ny) + base;
  assign bm1       = bitcnt - 3'd1;
  assign cmd_hit   = ({cmd, bus.MOSI} == CMD_READ);

`ifdef SPI_TX_HEADER_EN
  assign pix_phase = !in_hdr;
`else
  assign pix_phase = 1'b1;
`endif

  // Edge after the last pixel bit window
  assign frame_end = !cs_n && (state == DATA) && pix_phase && (bitcnt == 3'd0) && last_pix;

  // FRAME_CNT survives CS_N, so it lives outside the CS_N-cleared block
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST)            frame_cnt <= 8'd0;
    else if (frame_end) frame_cnt <= frame_cnt + 8'd1;
  end

  always_ff @(posedge SCLK or posedge RST or posedge cs_n) begin
    if (RST || cs_n) begin
      state      <= IDLE;
      cmd        <= 7'd0;
      bitcnt     <= 3'd0;
      x          <= '0;
      y          <= '0;
      base       <= 8'd0;
      miso       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SPI_TX_HEADER_EN
      in_hdr     <= 1'b0;
      hdr_sr     <= 16'd0;
      hdr_left   <= 4'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          cmd    <= {cmd[5:0], bus.MOSI};
          bitcnt <= 3'd1;
          state  <= CMD;
        end
        CMD: begin
          cmd <= {cmd[5:0], bus.MOSI};
          if (bitcnt == 3'd7) begin
            if (cmd_hit) begin
              state <= DATA;
              busy  <= 1'b1;
              base  <= frame_cnt;
              x     <= '0;
              y     <= '0;
`ifdef SPI_TX_HEADER_EN
              in_hdr   <= 1'b1;
              miso     <= HDR_TAG[7];
              hdr_sr   <= {HDR_TAG[6:0], frame_cnt, 1'b0};
              hdr_left <= 4'd15;
`else
              // pixel (0,0) is just the frame count
              miso   <= frame_cnt[PIX_MSB];
              bitcnt <= PIX_MSB;
`endif
            end else begin
              state <= DONE;
              miso  <= 1'b0;
            end
          end else begin
            bitcnt <= bitcnt + 3'd1;
          end
        end
        DATA: begin
`ifdef SPI_TX_HEADER_EN
          if (in_hdr) begin
            if (hdr_left != 4'd0) begin
              miso     <= hdr_sr[15];
              hdr_sr   <= {hdr_sr[14:0], 1'b0};
              hdr_left <= hdr_left - 4'd1;
            end else begin
              // x,y still 0 here, so cur_pix is pixel (0,0)
              in_hdr <= 1'b0;
              miso   <= cur_pix[PIX_MSB];
              bitcnt <= PIX_MSB;
            end
          end else
`endif
          if (frame_end) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            miso       <= 1'b0;
            state      <= DONE;
          end else if (bitcnt == 3'd0) begin
            x      <= nx;
            y      <= ny;
            bitcnt <= PIX_MSB;
            miso   <= nxt_pix[PIX_MSB];
          end else begin
            bitcnt <= bm1;
            miso   <= cur_pix[bm1];
          end
        end
        DONE: begin
          miso <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MISO       = miso;
  assign bus.BUSY       = busy;
  assign bus.FRAME_DONE = frame_done;
  assign bus.FRAME_CNT  = frame_cnt;
endmodule
